gpio_cfg_loader: RTL and testbench

Sequencer that holds the per-pad configuration words for the user I/O pad array and shifts them serially into the chain of per-pad GPIO control blocks. The control blocks drive the pad mode pins (DM, OE_N, INP_DIS, VTRIP_SEL, SLOW, HLD_OVR, analog selects). A management-side register port loads the shadow words. A start strobe shifts the whole chain and then pulses a parallel load, so every pad changes mode on the same cycle. Sits in housekeeping, between the management register bus and the pad ring.

---
 rtl/gpio_cfg_loader_pkg.sv | 34 +++
 rtl/gpio_cfg_loader_if.sv | 37 +++
 rtl/gpio_cfg_loader_phase_timer.sv | 32 +++
 rtl/gpio_cfg_loader.sv | 178 +++++++++++++++++
 tb/tb_gpio_cfg_loader.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_cfg_loader_pkg.sv
// -----------------------------------------------------------------------------
// gpio_cfg_pkg
// Shared definitions for the GPIO pad configuration loader: sequencer states,
// default configuration width/value and the bit positions of the fields inside
// one pad configuration word.
// -----------------------------------------------------------------------------
package gpio_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } state_t;

  localparam int CFG_BITS = 13;
  localparam logic [12:0] DEFAULT_CFG = 13'h0403;

  // Field positions inside a pad configuration word
  localparam int FLD_MGMT_EN     = 0;
  localparam int FLD_OUTENB      = 1;
  localparam int FLD_HOLDOVER    = 2;
  localparam int FLD_INP_DIS     = 3;
  localparam int FLD_IB_MODE_SEL = 4;
  localparam int FLD_ANALOG_EN   = 5;
  localparam int FLD_ANALOG_SEL  = 6;
  localparam int FLD_ANALOG_POL  = 7;
  localparam int FLD_SLOW_SEL    = 8;
  localparam int FLD_VTRIP_SEL   = 9;
  localparam int FLD_DM_LSB      = 10;
  localparam int FLD_DM_MSB      = 12;

endpackage

// File: rtl/gpio_cfg_loader_if.sv
// -----------------------------------------------------------------------------
// gpio_cfg_loader_if
// Bundles the management register port, the transfer control/status and the
// serial chain outputs of the GPIO configuration loader.
//   master : management side (drives cfg_we/cfg_addr/cfg_wdata/xfer_start)
//   slave  : the loader (drives cfg_rdata, busy, done and the serial_* chain)
// -----------------------------------------------------------------------------
interface gpio_cfg_loader_if #(
  parameter int TOTAL_PADS = 38,
  parameter int CFG_BITS   = gpio_cfg_pkg::CFG_BITS
);
  localparam int ADDR_W = (TOTAL_PADS > 1) ? $clog2(TOTAL_PADS) : 1;

  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [CFG_BITS-1:0] cfg_wdata;
  logic [CFG_BITS-1:0] cfg_rdata;
  logic                xfer_start;
  logic                busy;
  logic                done;
  logic                serial_clock;
  logic                serial_data;
  logic                serial_load;
  logic                serial_resetn;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, xfer_start,
    input  cfg_rdata, busy, done, serial_clock, serial_data, serial_load,
           serial_resetn
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, xfer_start,
    output cfg_rdata, busy, done, serial_clock, serial_data, serial_load,
           serial_resetn
  );
endinterface

// File: rtl/gpio_cfg_loader_phase_timer.sv
// -----------------------------------------------------------------------------
// gpio_cfg_phase_timer
// Down-counter that measures one serial phase of CLK_DIV clock cycles.
//   clk, rst      : clock, asynchronous active-high reset
//   i_reload      : restart the phase (asserted on every state entry)
//   o_phase_end   : high in the last cycle of the current phase
// -----------------------------------------------------------------------------
module gpio_cfg_phase_timer #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_reload,
  output logic o_phase_end
);
  localparam int TMR_W = $clog2(CLK_DIV + 1);
  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(CLK_DIV - 1);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= RELOAD;
    end else if (i_reload) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end
  end

  assign o_phase_end = (r_cnt == '0);
endmodule

// File: rtl/gpio_cfg_loader.sv
// -----------------------------------------------------------------------------
// gpio_cfg_loader
// Holds one configuration word per user pad and shifts the whole set into the
// pad control chain (last pad first, MSB first), then pulses serial_load so all
// pads switch mode on the same cycle.
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   bus (slave)        : cfg_we/cfg_addr/cfg_wdata/cfg_rdata register port,
//                        xfer_start/busy/done control, serial_clock/data/load/
//                        resetn chain outputs
// Build option: GPIO_CFG_AUTOLOAD_EN starts one transfer automatically right
// after reset so the pads receive DEFAULT_CFG without firmware action.
// -----------------------------------------------------------------------------
module gpio_cfg_loader #(
  parameter int TOTAL_PADS = 38,
  parameter int CFG_BITS   = gpio_cfg_pkg::CFG_BITS,
  parameter int CLK_DIV    = 1,
  parameter logic [CFG_BITS-1:0] DEFAULT_CFG = CFG_BITS'(gpio_cfg_pkg::DEFAULT_CFG)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  gpio_cfg_loader_if.slave bus
);
  import gpio_cfg_pkg::*;

  localparam int ADDR_W = (TOTAL_PADS > 1) ? $clog2(TOTAL_PADS) : 1;
  localparam int BIT_W  = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int N_BITS = TOTAL_PADS * CFG_BITS;
  localparam int CNT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(N_BITS - 1);
  localparam logic [ADDR_W-1:0] LAST_PAD  = ADDR_W'(TOTAL_PADS - 1);
  localparam logic [BIT_W-1:0]  MSB_IDX   = BIT_W'(CFG_BITS - 1);
  localparam logic [ADDR_W:0]   PAD_LIMIT = (ADDR_W + 1)'(TOTAL_PADS);

  logic [CFG_BITS-1:0] r_shadow [TOTAL_PADS];
  state_t              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [ADDR_W-1:0]   r_pad_idx;
  logic [BIT_W-1:0]    r_bit_idx;
  logic                r_busy, r_done, r_sclk, r_sdata, r_sload, r_resetn;

  logic                w_addr_ok, w_wr_en, w_start, w_first_bit;
  logic                w_phase_end, w_timer_reload;
  logic [ADDR_W-1:0]   w_next_pad;
  logic [BIT_W-1:0]    w_next_bit;
  logic [CFG_BITS-1:0] w_rdata;

  assign w_addr_ok = ({1'b0, bus.cfg_addr} < PAD_LIMIT);
  // Blocking writes while busy keeps the shadow frozen for the whole transfer,
  // so no separate snapshot register is needed.
  assign w_wr_en   = bus.cfg_we && !r_busy && w_addr_ok;

  genvar gi;
  generate
    for (gi = 0; gi < TOTAL_PADS; gi++) begin : g_shadow
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          r_shadow[gi] <= DEFAULT_CFG;
        end else if (w_wr_en && (bus.cfg_addr == ADDR_W'(gi))) begin
          r_shadow[gi] <= bus.cfg_wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    w_rdata = '0;
    if (w_addr_ok) w_rdata = r_shadow[bus.cfg_addr];
  end

  // A write landing on the same edge as the start must already be seen by
  // the first shifted bit, so bypass the shadow for the last pad.
  assign w_first_bit = (w_wr_en && (bus.cfg_addr == LAST_PAD))
                       ? bus.cfg_wdata[CFG_BITS-1]
                       : r_shadow[LAST_PAD][CFG_BITS-1];

  always_comb begin
    w_next_pad = r_pad_idx;
    w_next_bit = r_bit_idx - BIT_W'(1);
    if (r_bit_idx == '0) begin
      w_next_pad = r_pad_idx - ADDR_W'(1);
      w_next_bit = MSB_IDX;
    end
  end

`ifdef GPIO_CFG_AUTOLOAD_EN
  // High for exactly the cycle after serial_resetn rises.
  logic r_auto_go;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_auto_go <= 1'b0;
    else          r_auto_go <= ~r_resetn;
  end
  assign w_start = bus.xfer_start | r_auto_go;
`else
  assign w_start = bus.xfer_start;
`endif

  // Keep the timer primed while idle so the first phase is full length.
  assign w_timer_reload = (r_state == IDLE) || (r_state == DONE) || w_phase_end;

  gpio_cfg_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .i_reload    (w_timer_reload),
    .o_phase_end (w_phase_end)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_pad_idx <= '0;
      r_bit_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_sdata   <= 1'b0;
      r_sload   <= 1'b0;
      r_resetn  <= 1'b0;
    end else begin
      r_resetn <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= SHIFT_LO;
            r_bit_cnt <= '0;
            r_pad_idx <= LAST_PAD;
            r_bit_idx <= MSB_IDX;
            r_sdata   <= w_first_bit;
            r_busy    <= 1'b1;
          end
        end
        SHIFT_LO: begin
          if (w_phase_end) begin
            r_state <= SHIFT_HI;
            r_sclk  <= 1'b1;
          end
        end
        SHIFT_HI: begin
          if (w_phase_end) begin
            r_sclk <= 1'b0;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= LOAD;
              r_sload <= 1'b1;
              r_sdata <= 1'b0;
            end else begin
              r_state   <= SHIFT_LO;
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              r_pad_idx <= w_next_pad;
              r_bit_idx <= w_next_bit;
              r_sdata   <= r_shadow[w_next_pad][w_next_bit];
            end
          end
        end
        LOAD: begin
          if (w_phase_end) begin
            r_state <= DONE;
            r_sload <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_rdata     = w_rdata;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.serial_clock  = r_sclk;
  assign bus.serial_data   = r_sdata;
  assign bus.serial_load   = r_sload;
  assign bus.serial_resetn = r_resetn;
endmodule

// File: tb/tb_gpio_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_gpio_cfg_loader
// Two loader instances: the default 38x13 configuration and a small 2x4,
// CLK_DIV=2 chain. Expected serial bits are queued when a transfer is started
// and compared against the bits captured on serial_clock rising edges.
// -----------------------------------------------------------------------------
module tb_gpio_cfg_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  bit exp_q[$];
  bit obs_q[$];

  gpio_cfg_loader_if #(.TOTAL_PADS(38), .CFG_BITS(13)) big_if ();
  gpio_cfg_loader_if #(.TOTAL_PADS(2),  .CFG_BITS(4))  sml_if ();

  gpio_cfg_loader #(.TOTAL_PADS(38), .CFG_BITS(13), .CLK_DIV(1),
                    .DEFAULT_CFG(13'h0403)) u_big (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(big_if.slave));

  gpio_cfg_loader #(.TOTAL_PADS(2), .CFG_BITS(4), .CLK_DIV(2),
                    .DEFAULT_CFG(4'h3)) u_sml (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(sml_if.slave));

  // Monitor for the small chain: runs from the current negedge until busy
  // falls (or the budget expires, or the requested rise count triggers reset).
  task automatic observe_small(input int budget, input int rst_at_rise,
                               output int busy_cyc, output int rises,
                               output int loads, output int load_w,
                               output int dones, output bit timeout);
    bit seen, prev_sclk, prev_load;
    busy_cyc = 0; rises = 0; loads = 0; load_w = 0; dones = 0;
    timeout = 1'b1; seen = 1'b0;
    prev_sclk = sml_if.serial_clock;
    prev_load = sml_if.serial_load;
    obs_q.delete();
    for (int c = 0; c < budget; c++) begin
      if (sml_if.serial_clock && !prev_sclk) begin
        rises++;
        obs_q.push_back(sml_if.serial_data);
      end
      if (sml_if.serial_load) begin
        load_w++;
        if (!prev_load) loads++;
      end
      if (sml_if.done) dones++;
      prev_sclk = sml_if.serial_clock;
      prev_load = sml_if.serial_load;
      if (rst_at_rise > 0 && rises == rst_at_rise) begin
        rst = 1'b1;
        timeout = 1'b0;
        break;
      end
      if (sml_if.busy) begin
        busy_cyc++;
        seen = 1'b1;
      end else if (seen) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    $display("xfer small: busy=%0d rises=%0d loads=%0d load_w=%0d done=%0d timeout=%0d",
             busy_cyc, rises, loads, load_w, dones, timeout);
  endtask

  task automatic push_small(input logic [3:0] p1, input logic [3:0] p0);
    for (int b = 3; b >= 0; b--) exp_q.push_back(p1[b]);
    for (int b = 3; b >= 0; b--) exp_q.push_back(p0[b]);
  endtask

  task automatic start_small();
    @(negedge clk); sml_if.xfer_start = 1'b1;
    @(negedge clk); sml_if.xfer_start = 1'b0;
  endtask

`ifdef GPIO_CFG_AUTOLOAD_EN
  task automatic wait_idle();
    int c;
    c = 0;
    while ((big_if.busy || sml_if.busy) && c < 3000) begin
      @(negedge clk); c++;
    end
    n_checks++;
    if (big_if.busy || sml_if.busy) $display("FAIL wait_idle: busy still %0b%0b, required 00", big_if.busy, sml_if.busy);
    else n_pass++;
  endtask
`endif

  task automatic test_reset();
    logic [12:0] rd;
    @(negedge clk); #2 rst = 1'b1; #1;
    n_checks++;
    if ({sml_if.busy, sml_if.done, sml_if.serial_clock, sml_if.serial_data, sml_if.serial_load, sml_if.serial_resetn} !== 6'b0)
      $display("FAIL reset_outs_small: got %b required 000000", {sml_if.busy, sml_if.done, sml_if.serial_clock, sml_if.serial_data, sml_if.serial_load, sml_if.serial_resetn});
    else n_pass++;
    n_checks++;
    if ({big_if.busy, big_if.done, big_if.serial_clock, big_if.serial_data, big_if.serial_load, big_if.serial_resetn} !== 6'b0)
      $display("FAIL reset_outs_big: got %b required 000000", {big_if.busy, big_if.done, big_if.serial_clock, big_if.serial_data, big_if.serial_load, big_if.serial_resetn});
    else n_pass++;
    @(negedge clk); rst = 1'b0; #1;
    n_checks++;
    if (sml_if.serial_resetn !== 1'b0) $display("FAIL resetn_before_edge: got %b required 0", sml_if.serial_resetn);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({big_if.serial_resetn, sml_if.serial_resetn} !== 2'b11) $display("FAIL resetn_after_edge: got %b required 11", {big_if.serial_resetn, sml_if.serial_resetn});
    else n_pass++;
    for (int a = 0; a < 38; a++) begin
      big_if.cfg_addr = 6'(a); #1;
      rd = big_if.cfg_rdata;
      n_checks++;
      if (rd !== 13'h0403) $display("FAIL reset_shadow_big[%0d]: got %h required 0403", a, rd);
      else n_pass++;
    end
    for (int a = 0; a < 2; a++) begin
      sml_if.cfg_addr = 1'(a); #1;
      n_checks++;
      if (sml_if.cfg_rdata !== 4'h3) $display("FAIL reset_shadow_small[%0d]: got %h required 3", a, sml_if.cfg_rdata);
      else n_pass++;
    end
    big_if.cfg_addr = 6'd38; #1;
    n_checks++;
    if (big_if.cfg_rdata !== 13'h0) $display("FAIL read_oob_38: got %h required 0000", big_if.cfg_rdata);
    else n_pass++;
    big_if.cfg_addr = 6'd63; #1;
    n_checks++;
    if (big_if.cfg_rdata !== 13'h0) $display("FAIL read_oob_63: got %h required 0000", big_if.cfg_rdata);
    else n_pass++;
`ifdef GPIO_CFG_AUTOLOAD_EN
    wait_idle();
`endif
  endtask

`ifdef GPIO_CFG_AUTOLOAD_EN
  task automatic test_autoload();
    int busy_cyc, rises, dones, c;
    bit seen, prev_sclk, fin;
    logic [12:0] v;
    v = 13'h0403;
    for (int p = 37; p >= 0; p--)
      for (int b = 12; b >= 0; b--) exp_q.push_back(v[b]);
    obs_q.delete();
    busy_cyc = 0; rises = 0; dones = 0; seen = 0; fin = 0; prev_sclk = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      big_if.xfer_start = (c == 100);
      if (big_if.serial_clock && !prev_sclk) begin rises++; obs_q.push_back(big_if.serial_data); end
      prev_sclk = big_if.serial_clock;
      if (big_if.done) dones++;
      if (big_if.busy) begin busy_cyc++; seen = 1; end
      else if (seen) fin = 1;
    end
    big_if.xfer_start = 1'b0;
    $display("xfer autoload: busy=%0d rises=%0d done=%0d", busy_cyc, rises, dones);
    n_checks++;
    if (!fin) $display("FAIL autoload_timeout: busy did not complete, got %0d cycles", busy_cyc); else n_pass++;
    n_checks++;
    if (busy_cyc != 990) $display("FAIL autoload_busy: got %0d required 990", busy_cyc); else n_pass++;
    n_checks++;
    if (rises != 494) $display("FAIL autoload_rises: got %0d required 494", rises); else n_pass++;
    n_checks++;
    if (dones != 1) $display("FAIL autoload_done: got %0d required 1", dones); else n_pass++;
    while (exp_q.size() > 0) begin
      bit e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_checks++;
      if (o !== e) $display("FAIL autoload_bit: got %b required %b", o, e); else n_pass++;
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (big_if.busy !== 1'b0 || sml_if.busy !== 1'b0) $display("FAIL autoload_requeue: busy got %b%b required 00", big_if.busy, sml_if.busy);
    else n_pass++;
  endtask
`else
  task automatic test_no_autoload();
    bit any_busy;
    any_busy = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (big_if.busy || sml_if.busy) any_busy = 1;
    end
    n_checks++;
    if (any_busy) $display("FAIL no_autoload: busy seen got 1 required 0"); else n_pass++;
  endtask
`endif

  task automatic test_big_writes();
    @(negedge clk); big_if.cfg_we = 1'b1; big_if.cfg_addr = 6'd40; big_if.cfg_wdata = 13'h1FFF;
    @(negedge clk); big_if.cfg_addr = 6'd37; big_if.cfg_wdata = 13'h1ABC;
    @(negedge clk); big_if.cfg_we = 1'b0;
    big_if.cfg_addr = 6'd40; #1;
    n_checks++;
    if (big_if.cfg_rdata !== 13'h0) $display("FAIL oob_write: got %h required 0000", big_if.cfg_rdata); else n_pass++;
    big_if.cfg_addr = 6'd37; #1;
    n_checks++;
    if (big_if.cfg_rdata !== 13'h1ABC) $display("FAIL write37: got %h required 1abc", big_if.cfg_rdata); else n_pass++;
    big_if.cfg_addr = 6'd36; #1;
    n_checks++;
    if (big_if.cfg_rdata !== 13'h0403) $display("FAIL write36_untouched: got %h required 0403", big_if.cfg_rdata); else n_pass++;
  endtask

  task automatic test_transfer();
    int busy_cyc, rises, loads, load_w, dones;
    bit tmo, any_busy;
    @(negedge clk); sml_if.cfg_we = 1'b1; sml_if.cfg_addr = 1'b1; sml_if.cfg_wdata = 4'hA;
    @(negedge clk); sml_if.cfg_addr = 1'b0; sml_if.cfg_wdata = 4'h5;
    @(negedge clk); sml_if.cfg_we = 1'b0;
    push_small(4'hA, 4'h5);
    start_small();
    fork
      observe_small(200, 0, busy_cyc, rises, loads, load_w, dones, tmo);
      begin
        repeat (6) @(negedge clk);
        sml_if.cfg_we = 1'b1; sml_if.cfg_addr = 1'b0; sml_if.cfg_wdata = 4'hF; sml_if.xfer_start = 1'b1;
        @(negedge clk);
        sml_if.cfg_we = 1'b0; sml_if.xfer_start = 1'b0;
      end
    join
    n_checks++; if (tmo) $display("FAIL xfer_timeout: got 1 required 0"); else n_pass++;
    n_checks++; if (busy_cyc != 35) $display("FAIL xfer_busy: got %0d required 35", busy_cyc); else n_pass++;
    n_checks++; if (rises != 8) $display("FAIL xfer_rises: got %0d required 8", rises); else n_pass++;
    n_checks++; if (loads != 1) $display("FAIL xfer_loads: got %0d required 1", loads); else n_pass++;
    n_checks++; if (load_w != 2) $display("FAIL xfer_load_width: got %0d required 2", load_w); else n_pass++;
    n_checks++; if (dones != 1) $display("FAIL xfer_done: got %0d required 1", dones); else n_pass++;
    while (exp_q.size() > 0) begin
      bit e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_checks++;
      if (o !== e) $display("FAIL xfer_bit: got %b required %b", o, e); else n_pass++;
    end
    sml_if.cfg_addr = 1'b0; #1;
    n_checks++;
    if (sml_if.cfg_rdata !== 4'h5) $display("FAIL busy_write_dropped: got %h required 5", sml_if.cfg_rdata); else n_pass++;
    any_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (sml_if.busy) any_busy = 1;
    end
    n_checks++;
    if (any_busy) $display("FAIL start_not_queued: busy got 1 required 0"); else n_pass++;
  endtask

  task automatic test_same_cycle();
    int busy_cyc, rises, loads, load_w, dones;
    bit tmo;
    push_small(4'h3, 4'h5);
    @(negedge clk);
    sml_if.cfg_we = 1'b1; sml_if.cfg_addr = 1'b1; sml_if.cfg_wdata = 4'h3; sml_if.xfer_start = 1'b1;
    @(negedge clk);
    sml_if.cfg_we = 1'b0; sml_if.xfer_start = 1'b0;
    observe_small(200, 0, busy_cyc, rises, loads, load_w, dones, tmo);
    n_checks++; if (busy_cyc != 35) $display("FAIL same_cycle_busy: got %0d required 35", busy_cyc); else n_pass++;
    while (exp_q.size() > 0) begin
      bit e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_checks++;
      if (o !== e) $display("FAIL same_cycle_bit: got %b required %b", o, e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int busy_cyc, rises, loads, load_w, dones;
    bit tmo;
    start_small();
    observe_small(200, 5, busy_cyc, rises, loads, load_w, dones, tmo);
    #1;
    n_checks++;
    if ({sml_if.busy, sml_if.done, sml_if.serial_clock, sml_if.serial_data, sml_if.serial_load, sml_if.serial_resetn} !== 6'b0)
      $display("FAIL mid_reset_outs: got %b required 000000", {sml_if.busy, sml_if.done, sml_if.serial_clock, sml_if.serial_data, sml_if.serial_load, sml_if.serial_resetn});
    else n_pass++;
    n_checks++; if (rises != 5) $display("FAIL mid_reset_rises: got %0d required 5", rises); else n_pass++;
    n_checks++; if (loads != 0) $display("FAIL mid_reset_load: got %0d required 0", loads); else n_pass++;
    sml_if.cfg_addr = 1'b1; #1;
    n_checks++; if (sml_if.cfg_rdata !== 4'h3) $display("FAIL mid_reset_shadow1: got %h required 3", sml_if.cfg_rdata); else n_pass++;
    sml_if.cfg_addr = 1'b0; #1;
    n_checks++; if (sml_if.cfg_rdata !== 4'h3) $display("FAIL mid_reset_shadow0: got %h required 3", sml_if.cfg_rdata); else n_pass++;
    big_if.cfg_addr = 6'd37; #1;
    n_checks++; if (big_if.cfg_rdata !== 13'h0403) $display("FAIL mid_reset_big37: got %h required 0403", big_if.cfg_rdata); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_checks++; if (sml_if.serial_resetn !== 1'b1) $display("FAIL mid_reset_resetn: got %b required 1", sml_if.serial_resetn); else n_pass++;
`ifdef GPIO_CFG_AUTOLOAD_EN
    wait_idle();
`endif
    push_small(4'h3, 4'h3);
    start_small();
    observe_small(200, 0, busy_cyc, rises, loads, load_w, dones, tmo);
    n_checks++; if (busy_cyc != 35) $display("FAIL post_reset_busy: got %0d required 35", busy_cyc); else n_pass++;
    n_checks++; if (loads != 1) $display("FAIL post_reset_load: got %0d required 1", loads); else n_pass++;
    n_checks++; if (dones != 1) $display("FAIL post_reset_done: got %0d required 1", dones); else n_pass++;
    while (exp_q.size() > 0) begin
      bit e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_checks++;
      if (o !== e) $display("FAIL post_reset_bit: got %b required %b", o, e); else n_pass++;
    end
  endtask

  initial begin
    big_if.cfg_we = 1'b0; big_if.cfg_addr = '0; big_if.cfg_wdata = '0; big_if.xfer_start = 1'b0;
    sml_if.cfg_we = 1'b0; sml_if.cfg_addr = '0; sml_if.cfg_wdata = '0; sml_if.xfer_start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
`ifdef GPIO_CFG_AUTOLOAD_EN
    test_autoload();
`else
    test_no_autoload();
`endif
    test_big_writes();
    test_transfer();
    test_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
